iopmp_scan_checker: RTL and testbench

IOPMP_SCAN_CHECKER -- requirements
Module: iopmp_scan_checker

---
 rtl/iopmp_scan_checker.sv | 192 +++++++++++++++++++
 tb/tb_iopmp_scan_checker.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/iopmp_scan_checker.sv
// iopmp_scan_checker: multi-beat IOPMP entry scan with per-source masks, error capture and deny counting
package riscv;
    typedef enum logic [1:0] {OFF = 2'b00, TOR = 2'b01, NA4 = 2'b10, NAPOT = 2'b11} pmp_addr_mode_t;
    typedef struct packed {
        logic x;
        logic w;
        logic r;
    } pmpcfg_access_t;
    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmpcfg_access_t access_type;
    } pmpcfg_t;
    typedef enum logic [2:0] {
        ACCESS_NONE  = 3'b000,
        ACCESS_READ  = 3'b001,
        ACCESS_WRITE = 3'b010,
        ACCESS_EXEC  = 3'b100
    } pmp_access_t;
endpackage

module iopmp_scan_checker #(
    parameter int unsigned PLEN           = 56,
    parameter int unsigned PMP_LEN        = 54,
    parameter int unsigned NR_ENTRIES     = 16,
    parameter int unsigned EPC            = 4,
    parameter int unsigned NR_SRC         = 4,
    parameter int unsigned PMPGranularity = 2,
    parameter int unsigned SRC_W          = (NR_SRC > 1) ? $clog2(NR_SRC) : 1,
    parameter int unsigned ENTRY_W        = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [PMP_LEN-1:0]        addr_reg_i [NR_ENTRIES],
    input  riscv::pmpcfg_t            conf_reg_i [NR_ENTRIES],
    input  logic [NR_ENTRIES-1:0]     src_mask_i [NR_SRC],
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [PLEN-1:0]           req_addr_i,
    input  riscv::pmp_access_t        req_access_i,
    input  logic [SRC_W-1:0]          req_src_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic                      rsp_allow_o,
    output logic                      rsp_hit_o,
    output logic [ENTRY_W-1:0]        rsp_entry_o,
    output logic                      err_valid_o,
    output logic [PLEN-1:0]           err_addr_o,
    output logic [SRC_W-1:0]          err_src_o,
    output riscv::pmp_access_t        err_access_o,
    output logic                      err_ovf_o,
    input  logic                      err_clear_i,
    output logic [15:0]               deny_cnt_o
);
    localparam int unsigned K      = NR_ENTRIES / EPC;
    localparam int unsigned BEAT_W = (K > 1) ? $clog2(K) : 1;
    // NAPOT ignores the granule's low address bits; TOR bounds are granule aligned
    localparam logic [PLEN-1:0] NAPOT_LO = {PLEN{1'b1}} >> (PLEN - PMPGranularity - 1);
    localparam logic [PLEN-1:0] TOR_LO   = {PLEN{1'b1}} >> (PLEN - PMPGranularity - 2);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t                   state_q, state_d;
    logic [BEAT_W-1:0]        beat_q;
    logic [PLEN-1:0]          addr_q;
    riscv::pmp_access_t       acc_q;
    logic [SRC_W-1:0]         src_q;
    logic [EPC-1:0]           cand;
    logic [ENTRY_W-1:0]       cidx [EPC];
    logic                     found, dec_allow, done, deny;
    logic [ENTRY_W-1:0]       dec_entry;
    logic                     unused_cfg;

    function automatic logic entry_match(input logic [PLEN-1:0] a, input logic [PMP_LEN-1:0] cur,
                                         input logic [PMP_LEN-1:0] prev, input riscv::pmp_addr_mode_t mode);
        logic [PLEN-1:0] v, care, lo, hi;
        v    = PLEN'({cur, 2'b11}) | NAPOT_LO;
        care = ~(v ^ (v + PLEN'(1)));
        lo   = PLEN'({prev, 2'b00}) & ~TOR_LO;
        hi   = PLEN'({cur, 2'b00}) & ~TOR_LO;
        return (mode == riscv::TOR)   ? (a >= lo && a < hi) :
               (mode == riscv::NAPOT) ? ((a & care) == (v & care)) :
               (mode == riscv::NA4)   ? (PMPGranularity == 0 && (a & ~PLEN'(3)) == PLEN'({cur, 2'b00})) : 1'b0;
    endfunction

    // Evaluate the current beat's slice of entries against the latched request
    always_comb begin
        for (int j = 0; j < EPC; j++) begin
            cidx[j] = ENTRY_W'(32'(beat_q) * EPC + j);
            cand[j] = entry_match(addr_q, addr_reg_i[cidx[j]],
                                  (cidx[j] == '0) ? '0 : addr_reg_i[cidx[j] - ENTRY_W'(1)],
                                  conf_reg_i[cidx[j]].addr_mode)
                      && src_mask_i[src_q][cidx[j]] && conf_reg_i[cidx[j]].addr_mode != riscv::OFF;
        end
    end

    // Lowest-index candidate in the beat decides
    always_comb begin
        found     = 1'b0;
        dec_allow = 1'b0;
        dec_entry = '0;
        for (int j = EPC - 1; j >= 0; j--) begin
            if (cand[j]) begin
                found     = 1'b1;
                dec_entry = cidx[j];
                dec_allow = (3'(acc_q) & conf_reg_i[cidx[j]].access_type) == 3'(acc_q);
            end
        end
    end

    assign done        = state_q == SCAN && (found || beat_q == BEAT_W'(K - 1));
    assign deny        = done && !dec_allow;
    assign req_ready_o = state_q == IDLE;
    assign rsp_valid_o = state_q == RESP;

    // Lock and reserved config bits have no meaning for this checker
    always_comb begin
        unused_cfg = 1'b0;
        for (int i = 0; i < NR_ENTRIES; i++)
            unused_cfg = unused_cfg ^ conf_reg_i[i].locked ^ (^conf_reg_i[i].reserved);
    end

    // Next state: accept in IDLE, leave SCAN on a decision, leave RESP on handshake
    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE && req_valid_i) ? SCAN :
                  done                             ? RESP :
                  (state_q == RESP && rsp_ready_i) ? IDLE : state_q;
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Request latch, beat counter and response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            acc_q       <= riscv::ACCESS_NONE;
            src_q       <= '0;
            beat_q      <= '0;
            rsp_allow_o <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_entry_o <= '0;
        end else begin
            if (req_valid_i && req_ready_o) begin
                addr_q <= req_addr_i;
                acc_q  <= req_access_i;
                src_q  <= req_src_i;
                beat_q <= '0;
            end else if (state_q == SCAN) begin
                beat_q <= beat_q + BEAT_W'(1);
            end
            if (done) begin
                rsp_allow_o <= dec_allow;
                rsp_hit_o   <= found;
                rsp_entry_o <= dec_entry;
            end
        end
    end

    // Keep the first unacknowledged deny; further denies only flag overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_o  <= 1'b0;
            err_addr_o   <= '0;
            err_src_o    <= '0;
            err_access_o <= riscv::ACCESS_NONE;
            err_ovf_o    <= 1'b0;
        end else if (deny && (!err_valid_o || err_clear_i)) begin
            err_valid_o  <= 1'b1;
            err_addr_o   <= addr_q;
            err_src_o    <= src_q;
            err_access_o <= acc_q;
            err_ovf_o    <= 1'b0;
        end else if (deny) begin
            err_ovf_o    <= 1'b1;
        end else if (err_clear_i) begin
            err_valid_o  <= 1'b0;
            err_ovf_o    <= 1'b0;
        end
    end

    // Saturating deny counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                              deny_cnt_o <= '0;
        else if (deny && deny_cnt_o != 16'hFFFF) deny_cnt_o <= deny_cnt_o + 16'd1;
    end
endmodule

// File: tb/tb_iopmp_scan_checker.sv
// tb_iopmp_scan_checker: vector table plus corner sequences with a response scoreboard
module tb_iopmp_scan_checker;
    localparam int PLEN = 56, PMP_LEN = 54, NR_ENTRIES = 16, NR_SRC = 4;

    typedef struct {
        logic [55:0] addr;
        logic [2:0]  acc;
        logic [1:0]  src;
        logic        allow;
        logic        hit;
        logic [3:0]  entry;
        int          lat;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic [PMP_LEN-1:0]    addr_reg [NR_ENTRIES];
    riscv::pmpcfg_t        conf_reg [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] src_mask [NR_SRC];
    logic                  req_valid = 1'b0, rsp_ready = 1'b1, err_clear = 1'b0;
    logic [PLEN-1:0]       req_addr = '0;
    riscv::pmp_access_t    req_access = riscv::ACCESS_NONE;
    logic [1:0]            req_src = '0;
    logic                  req_ready, rsp_valid, rsp_allow, rsp_hit, err_valid, err_ovf;
    logic [3:0]            rsp_entry;
    logic [PLEN-1:0]       err_addr;
    logic [1:0]            err_src;
    riscv::pmp_access_t    err_access;
    logic [15:0]           deny_cnt;

    int checks = 0, errors = 0;
    vec_t exp_q[$];
    vec_t tbl [15];
    logic        m_valid = 0, m_ovf = 0;
    logic [55:0] m_addr = '0;
    logic [1:0]  m_src = '0;
    logic [2:0]  m_acc = '0;
    int          m_cnt = 0;

    iopmp_scan_checker dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .addr_reg_i(addr_reg), .conf_reg_i(conf_reg),
        .src_mask_i(src_mask), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_access_i(req_access), .req_src_i(req_src),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_allow_o(rsp_allow),
        .rsp_hit_o(rsp_hit), .rsp_entry_o(rsp_entry), .err_valid_o(err_valid),
        .err_addr_o(err_addr), .err_src_o(err_src), .err_access_o(err_access),
        .err_ovf_o(err_ovf), .err_clear_i(err_clear), .deny_cnt_o(deny_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_err(input string tag);
        chk({tag, "_err_valid"}, 64'(err_valid), 64'(m_valid));
        chk({tag, "_err_ovf"}, 64'(err_ovf), 64'(m_ovf));
        chk({tag, "_err_addr"}, 64'(err_addr), 64'(m_addr));
        chk({tag, "_err_src"}, 64'(err_src), 64'(m_src));
        chk({tag, "_err_access"}, 64'(err_access), 64'(m_acc));
        chk({tag, "_deny_cnt"}, 64'(deny_cnt), 64'(m_cnt));
    endtask

    task automatic do_req(input string tag, input vec_t v, input int stall, input bit clr);
        vec_t e;
        int cyc;
        @(posedge clk_i); #1;
        cyc = 0;
        while (!req_ready && cyc < 50) begin @(posedge clk_i); #1; cyc++; end
        exp_q.push_back(v);
        req_addr   = v.addr;
        req_access = riscv::pmp_access_t'(v.acc);
        req_src    = v.src;
        req_valid  = 1'b1;
        rsp_ready  = (stall == 0);
        @(posedge clk_i); #1;
        req_valid = 1'b0;
        err_clear = clr;
        @(negedge clk_i);
        chk({tag, "_accepted"}, 64'(req_ready), 64'(0));
        cyc = 1;
        while (!rsp_valid && cyc < 30) begin @(posedge clk_i); cyc++; @(negedge clk_i); end
        err_clear = 1'b0;
        e = exp_q.pop_front();
        chk({tag, "_latency"}, 64'(cyc), 64'(e.lat));
        chk({tag, "_allow"}, 64'(rsp_allow), 64'(e.allow));
        chk({tag, "_hit"}, 64'(rsp_hit), 64'(e.hit));
        chk({tag, "_entry"}, 64'(rsp_entry), 64'(e.entry));
        if (!e.allow) begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            if (!m_valid || clr) begin
                m_valid = 1; m_addr = e.addr; m_src = e.src; m_acc = e.acc; m_ovf = 0;
            end else m_ovf = 1;
        end else if (clr) begin
            m_valid = 0; m_ovf = 0;
        end
        chk_err(tag);
        for (int s = 0; s < stall; s++) begin
            chk({tag, "_stall_valid"}, 64'(rsp_valid), 64'(1));
            chk({tag, "_stall_allow"}, 64'(rsp_allow), 64'(e.allow));
            chk({tag, "_stall_entry"}, 64'(rsp_entry), 64'(e.entry));
            chk({tag, "_stall_ready"}, 64'(req_ready), 64'(0));
            if (s == stall - 1) rsp_ready = 1'b1;
            else begin @(posedge clk_i); @(negedge clk_i); end
        end
        @(posedge clk_i); #1;
        chk({tag, "_idle_after"}, 64'({req_ready, rsp_valid}), 64'(2'b10));
    endtask

    initial begin
        for (int i = 0; i < NR_ENTRIES; i++) begin addr_reg[i] = '0; conf_reg[i] = '0; end
        addr_reg[2]  = 54'h200001FF; conf_reg[2].addr_mode  = riscv::NAPOT; conf_reg[2].access_type  = 3'b011;
        addr_reg[3]  = 54'h20001FFF; conf_reg[3].addr_mode  = riscv::NAPOT; conf_reg[3].access_type  = 3'b111;
        addr_reg[5]  = 54'h400;      conf_reg[5].addr_mode  = riscv::NA4;   conf_reg[5].access_type  = 3'b111;
        addr_reg[8]  = 54'h20000000;
        addr_reg[9]  = 54'h24000000; conf_reg[9].addr_mode  = riscv::TOR;   conf_reg[9].access_type  = 3'b001;
        addr_reg[13] = 54'h24000000;
        addr_reg[14] = 54'h28000000; conf_reg[14].addr_mode = riscv::TOR;   conf_reg[14].access_type = 3'b100;
        addr_reg[15] = '1;           conf_reg[15].addr_mode = riscv::NAPOT; conf_reg[15].access_type = 3'b111;
        src_mask[0] = 16'h000C; src_mask[1] = 16'h0200; src_mask[2] = 16'h8020; src_mask[3] = 16'h4000;

        tbl[0]  = '{56'h80000100, 3'b001, 2'd0, 1'b1, 1'b1, 4'd2,  2};
        tbl[1]  = '{56'h80000100, 3'b010, 2'd1, 1'b0, 1'b1, 4'd9,  4};
        tbl[2]  = '{56'h00001000, 3'b001, 2'd0, 1'b0, 1'b0, 4'd0,  5};
        tbl[3]  = '{56'h80000100, 3'b000, 2'd1, 1'b1, 1'b1, 4'd9,  4};
        tbl[4]  = '{56'h8FFFFFFC, 3'b001, 2'd1, 1'b1, 1'b1, 4'd9,  4};
        tbl[5]  = '{56'h90000000, 3'b001, 2'd1, 1'b0, 1'b0, 4'd0,  5};
        tbl[6]  = '{56'h7FFFFFFC, 3'b001, 2'd1, 1'b0, 1'b0, 4'd0,  5};
        tbl[7]  = '{56'h80000FFC, 3'b010, 2'd0, 1'b1, 1'b1, 4'd2,  2};
        tbl[8]  = '{56'h80001000, 3'b001, 2'd0, 1'b1, 1'b1, 4'd3,  2};
        tbl[9]  = '{56'h80000100, 3'b100, 2'd0, 1'b0, 1'b1, 4'd2,  2};
        tbl[10] = '{56'h80010000, 3'b001, 2'd0, 1'b0, 1'b0, 4'd0,  5};
        tbl[11] = '{56'h00001000, 3'b001, 2'd2, 1'b1, 1'b1, 4'd15, 5};
        tbl[12] = '{56'h90000000, 3'b100, 2'd3, 1'b1, 1'b1, 4'd14, 5};
        tbl[13] = '{56'h90000000, 3'b001, 2'd3, 1'b0, 1'b1, 4'd14, 5};
        tbl[14] = '{56'h80000100, 3'b010, 2'd2, 1'b1, 1'b1, 4'd15, 5};

        repeat (2) @(negedge clk_i);
        chk("reset_ready", 64'(req_ready), 64'(1));
        chk("reset_rsp", 64'({rsp_valid, rsp_allow, rsp_hit, rsp_entry}), 64'(0));
        chk_err("reset");
        rst_ni = 1'b1;

        for (int i = 0; i < 15; i++) do_req($sformatf("vec%0d", i), tbl[i], 0, 1'b0);

        @(posedge clk_i); #1; err_clear = 1'b1;
        @(posedge clk_i); #1; err_clear = 1'b0;
        m_valid = 0; m_ovf = 0;
        @(negedge clk_i);
        chk("clear_valid", 64'(err_valid), 64'(0));
        chk("clear_ovf", 64'(err_ovf), 64'(0));

        do_req("recapture", tbl[10], 0, 1'b0);
        do_req("overflow", tbl[5], 0, 1'b0);
        do_req("clr_capture", '{56'h80000200, 3'b100, 2'd0, 1'b0, 1'b1, 4'd2, 2}, 0, 1'b1);
        do_req("stall", tbl[0], 3, 1'b0);

        @(posedge clk_i); #1;
        req_addr = 56'h1000; req_access = riscv::ACCESS_READ; req_src = 2'd0; req_valid = 1'b1;
        @(posedge clk_i); #1; req_valid = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b0; #2; rst_ni = 1'b1;
        m_valid = 0; m_ovf = 0; m_addr = '0; m_src = '0; m_acc = '0; m_cnt = 0;
        begin
            logic saw;
            saw = 1'b0;
            repeat (8) begin @(negedge clk_i); if (rsp_valid) saw = 1'b1; end
            chk("rst_no_rsp", 64'(saw), 64'(0));
        end
        chk("rst_ready", 64'(req_ready), 64'(1));
        chk_err("rst_abort");
        do_req("after_rst", tbl[1], 0, 1'b0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
